// File: rtl/led_sequencer.sv
// LED pattern generator: a prescaler (or single-step presses while paused)
// advances the LED bank through binary count, walking one, bounce or blink.
module led_sequencer #(
  parameter int CLK_DIV = 100000000,
  parameter int LED_W   = 4
) (
  input  logic             clock,
  input  logic             n_reset,
  input  logic [1:0]       mode,
  input  logic             run,
  input  logic             dir,
  input  logic             step,
  output logic [LED_W-1:0] led,
  output logic             tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [LED_W-1:0] LED_ONE = LED_W'(1);

  localparam logic [1:0] MODE_BINARY = 2'd0;
  localparam logic [1:0] MODE_WALK   = 2'd1;
  localparam logic [1:0] MODE_BOUNCE = 2'd2;
  localparam logic [1:0] MODE_BLINK  = 2'd3;

  // Bounce travel direction is the only piece of pattern state beyond led.
  typedef enum logic {
    BDIR_LEFT  = 1'b0,
    BDIR_RIGHT = 1'b1
  } bdir_t;

  logic [CNT_W-1:0] cnt, cnt_next;
  logic [1:0]       mode_q;
  logic             step_q;
  bdir_t            bdir, bdir_next;
  logic [LED_W-1:0] led_next;
  logic             tick_next;

  logic mode_chg;
  logic auto_adv;
  logic step_adv;
  logic adv;

  // Value the LED bank starts from when a mode is entered.
  function automatic logic [LED_W-1:0] mode_init(input logic [1:0] m);
    logic [LED_W-1:0] v;
    case (m)
      MODE_WALK, MODE_BOUNCE: v = LED_ONE;
      default:                v = '0;
    endcase
    return v;
  endfunction

  // Up/down binary count; natural width overflow gives the wrap.
  function automatic logic [LED_W-1:0] next_binary(input logic [LED_W-1:0] v,
                                                   input logic d);
    return d ? (v - LED_ONE) : (v + LED_ONE);
  endfunction

  // Rotate a walking pattern; an empty bank restarts at bit 0.
  function automatic logic [LED_W-1:0] next_walk(input logic [LED_W-1:0] v,
                                                 input logic d);
    logic [LED_W-1:0] r;
    if (v == '0)
      r = LED_ONE;
    else if (d)
      r = {v[0], v[LED_W-1:1]};
    else
      r = {v[LED_W-2:0], v[LED_W-1]};
    return r;
  endfunction

  assign mode_chg = (mode != mode_q);
  assign auto_adv = run & (cnt == CNT_MAX);
  assign step_adv = step & ~step_q & ~run;
  assign adv      = auto_adv | step_adv;

  // Next-state logic: mode change beats any coincident advance.
  always_comb begin
    led_next  = led;
    bdir_next = bdir;
    tick_next = 1'b0;

    if (!run || mode_chg || (cnt == CNT_MAX))
      cnt_next = '0;
    else
      cnt_next = cnt + CNT_W'(1);

    if (mode_chg) begin
      led_next  = mode_init(mode);
      bdir_next = BDIR_LEFT;
    end else if (adv) begin
      tick_next = 1'b1;
      case (mode_q)
        MODE_BINARY: led_next = next_binary(led, dir);
        MODE_WALK:   led_next = next_walk(led, dir);
        MODE_BOUNCE: begin
          if (!$onehot(led)) begin
            led_next  = LED_ONE;
            bdir_next = BDIR_LEFT;
          end else if (bdir == BDIR_LEFT) begin
            if (led[LED_W-1]) begin
              led_next  = led >> 1;
              bdir_next = BDIR_RIGHT;
            end else begin
              led_next  = led << 1;
            end
          end else begin
            if (led[0]) begin
              led_next  = led << 1;
              bdir_next = BDIR_LEFT;
            end else begin
              led_next  = led >> 1;
            end
          end
        end
        MODE_BLINK:  led_next = ~led;
        default:     led_next = led;
      endcase
    end
  end

  // State registers; everything clears asynchronously on n_reset.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      cnt    <= '0;
      mode_q <= MODE_BINARY;
      step_q <= 1'b0;
      bdir   <= BDIR_LEFT;
      led    <= '0;
      tick   <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      mode_q <= mode;
      step_q <= step;
      bdir   <= bdir_next;
      led    <= led_next;
      tick   <= tick_next;
    end
  end

endmodule

// File: doc/led_sequencer.md
Name: led_sequencer

Overview:
Parametrised LED pattern generator driving a board LED bank from the system clock. An internal prescaler produces an advance strobe every CLK_DIV clocks, or a single advance per step press when paused. On each advance the LED register moves to the next value of the selected pattern: binary count, walking one, bounce, or blink. Sits directly behind board switch/button synchronisers and drives the LED pins.

Parameters:
CLK_DIV, 100000000, clocks per automatic advance; legal range ≥2; prescaler width is $clog2(CLK_DIV)
LED_W, 4, number of LEDs / pattern width; legal range ≥2

Ports:
clock  input  1  system clock, all logic on rising edge
n_reset  input  1  asynchronous, active-low reset
mode  input  2  pattern select: 0 binary, 1 walking one, 2 bounce, 3 blink; synchronous to clock
run  input  1  1 = free-run on prescaler, 0 = paused / single-step
dir  input  1  0 = up/left, 1 = down/right; used in modes 0 and 1 only
step  input  1  single-step request, level; already synchronised/debounced upstream
led  output  LED_W  LED drive, registered
tick  output  1  registered, high for exactly the one cycle in which led shows a newly advanced value

Behaviour:
- Reset (asynchronous, n_reset=0): led=0, tick=0, prescaler cnt=0, mode_q=0, step_q=0, bounce direction=left. All state clears immediately, including mid-pattern.
- Prescaler: run=1 -> cnt increments 0..CLK_DIV-1 and wraps to 0. auto_adv = run & (cnt==CLK_DIV-1). run=0 -> cnt forced to 0 every cycle. After run rises, the first advance lands exactly CLK_DIV clocks later.
- Step: step_q <= step every cycle. step_adv = step & ~step_q & ~run. Exactly one advance per rising edge. Step is ignored while run=1; holding step high gives only one advance.
- Mode change: mode_q <= mode every cycle. If mode != mode_q, then:
  - led loads the initial value of the new mode (0 -> 0, 1 -> 1, 2 -> 1 with bounce dir=left, 3 -> 0).
  - cnt clears to 0, tick=0.
  - Any coincident auto_adv or step_adv is discarded; mode change has priority.
  - Because mode_q resets to 0, a nonzero mode held through reset loads its initial value on the first clock after reset release.
- Advance (adv = auto_adv | step_adv, no mode change): led <= next(led); tick <= 1. Otherwise tick <= 0 and led holds.
- Next-value rules, all arithmetic modulo 2^LED_W:
  - Mode 0 (binary): dir=0 -> led+1, with all-ones wrapping to 0. dir=1 -> led-1, with 0 wrapping to all-ones.
  - Mode 1 (walking one): dir=0 rotate left, MSB into bit0. dir=1 rotate right, bit0 into MSB. If led==0, load 1 instead of rotating.
  - Mode 2 (bounce): a single lit bit moves toward the current bounce direction. At the end bit (MSB when going left, bit0 when going right), the direction flips in the same advance and the bit moves one back. Ends are shown once, not twice. For LED_W=4 the sequence is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, … If led is not one-hot, load 1 with dir=left.
  - Mode 3 (blink): led <= ~led, giving alternating all-zeros and all-ones.
- dir changes take effect at the next advance with no glitch; dir is sampled on the advance cycle.
- Latency: led and tick update on the clock edge at which cnt wraps (auto) or at which the step rising edge is sampled (step). tick is coincident with the new led value.

Test Plan:
- CLK_DIV=4, LED_W=4, mode=0, run=1, dir=0 from reset -> tick every 4th clock; led goes 0, 1, 2 … 15, 0; tick never two cycles in a row.
- mode=0, dir=1 from led=0 -> next advance gives led=1111, then 1110.
- mode=1, dir=0 -> led 0001, 0010, 0100, 1000, 0001. Switch dir=1 at led=0100 -> next advances give 0010, then 0001.
- mode=2 -> 16 advances follow the exact bounce sequence above; led always one-hot.
- run=0, step held high for 10 clocks, then low, then pulsed once more -> exactly 2 advances and 2 tick pulses; cnt stays 0. With run=1, step pulses are ignored.
- Mode 0 at led=0101; change to mode=3 on the same cycle as an auto advance -> led=0000, tick=0. First blink advance comes 4 clocks later giving 1111. Assert n_reset mid-run -> led=0 and tick=0 immediately, without waiting for a clock edge.
